// File: rtl/fsm_lane_arbiter_pkg.sv
// rtl/fsm_lane_arbiter_pkg.sv - shared types and constants for the lane arbiter
package fsm_lane_arbiter_pkg;

  localparam int NUM_REQ = 4;
  localparam logic [3:0] PATTERN = 4'b1011;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SHIFT  = 2'd1,
    ST_REPORT = 2'd2
  } state_t;

  // First requesting index at or after ptr, wrapping 3 -> 0; returns ptr when nothing is requesting
  function automatic logic [1:0] rr_pick(input logic [NUM_REQ-1:0] req, input logic [1:0] ptr);
    logic [1:0] idx;
    logic       found;
    rr_pick = ptr;
    found   = 1'b0;
    for (int off = 0; off < NUM_REQ; off++) begin
      idx = ptr + 2'(off);
      if (!found && req[idx]) begin
        rr_pick = idx;
        found   = 1'b1;
      end
    end
  endfunction

endpackage

// File: rtl/fsm_lane_arbiter_seq_detect.sv
// rtl/fsm_lane_arbiter_seq_detect.sv - overlapping serial detector for the fixed lane pattern
module seq_detect
  import fsm_lane_arbiter_pkg::*;
(
  input  logic clock,
  input  logic reset,
  input  logic clr,
  input  logic valid,
  input  logic bit_in,
  output logic hit
);

  // Last three consumed bits, oldest in the MSB
  logic [2:0] r_hist;
  // Number of bits consumed since clear, saturating at 3, so stale history never completes a match
  logic [1:0] r_fill;

  // A match completes when three bits are already held and the incoming bit closes the pattern
  assign hit = valid && (r_fill == 2'd3) && ({r_hist, bit_in} == PATTERN);

  // History and fill count; keeping the full window after a hit gives overlapping matches for free
  always_ff @(posedge clock) begin
    if (reset || clr) begin
      r_hist <= 3'd0;
      r_fill <= 2'd0;
    end else if (valid) begin
      r_hist <= {r_hist[1:0], bit_in};
      if (r_fill != 2'd3) begin
        r_fill <= r_fill + 2'd1;
      end
    end
  end

endmodule

// File: rtl/fsm_lane_arbiter.sv
// rtl/fsm_lane_arbiter.sv - round-robin arbiter feeding one serial pattern-detector lane
module fsm_lane_arbiter
  import fsm_lane_arbiter_pkg::*;
#(
  parameter int FRAME_BITS = 8
) (
  input  logic                            clock,
  input  logic                            reset,
  input  logic [NUM_REQ-1:0]              req,
  input  logic [NUM_REQ*FRAME_BITS-1:0]   data,
  output logic [NUM_REQ-1:0]              grant,
  output logic                            busy,
  output logic                            ser_out,
  output logic                            done,
  output logic [1:0]                      done_id,
  output logic [3:0]                      match_cnt
);

  localparam logic [3:0] LAST_BIT = 4'(FRAME_BITS - 1);

  state_t                  r_state;
  state_t                  w_next_state;
  logic [1:0]              r_rr_ptr;
  logic [1:0]              r_grant_id;
  logic [NUM_REQ-1:0]      r_grant;
  logic [FRAME_BITS-1:0]   r_shreg;
  logic [3:0]              r_bit_cnt;
  logic [3:0]              r_match_cnt;
  logic [1:0]              r_id_hold;
  logic [3:0]              r_cnt_hold;

  logic                    w_start;
  logic                    w_shift;
  logic                    w_hit;
  logic [1:0]              w_pick;
  logic [FRAME_BITS-1:0]   w_word;

  assign w_pick = rr_pick(req, r_rr_ptr);

  // Select the frame word of the requester that would be granted this cycle
  always_comb begin
    w_word = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (w_pick == 2'(i)) begin
        w_word = data[i*FRAME_BITS +: FRAME_BITS];
      end
    end
  end

  // Next-state and per-cycle strobes for the frame sequencer
  always_comb begin
    w_next_state = r_state;
    w_start      = 1'b0;
    w_shift      = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (|req) begin
          w_start      = 1'b1;
          w_next_state = ST_SHIFT;
        end
      end
      ST_SHIFT: begin
        w_shift = 1'b1;
        if (r_bit_cnt == LAST_BIT) begin
          w_next_state = ST_REPORT;
        end
      end
      ST_REPORT: begin
        w_next_state = ST_IDLE;
      end
      default: begin
        w_next_state = ST_IDLE;
      end
    endcase
  end

  // Detector is cleared on the grant edge so nothing leaks from the previous frame
  seq_detect u_seq_detect (
    .clock  (clock),
    .reset  (reset),
    .clr    (w_start),
    .valid  (w_shift),
    .bit_in (r_shreg[FRAME_BITS-1]),
    .hit    (w_hit)
  );

  // State register, grant latch, shifter, bit counter and match counter
  always_ff @(posedge clock) begin
    if (reset) begin
      r_state     <= ST_IDLE;
      r_rr_ptr    <= 2'd0;
      r_grant_id  <= 2'd0;
      r_grant     <= '0;
      r_shreg     <= '0;
      r_bit_cnt   <= 4'd0;
      r_match_cnt <= 4'd0;
      r_id_hold   <= 2'd0;
      r_cnt_hold  <= 4'd0;
    end else begin
      r_state <= w_next_state;
      if (w_start) begin
        r_grant_id  <= w_pick;
        r_grant     <= NUM_REQ'(1) << w_pick;
        r_shreg     <= w_word;
        r_bit_cnt   <= 4'd0;
        r_match_cnt <= 4'd0;
      end
      if (w_shift) begin
        r_shreg   <= {r_shreg[FRAME_BITS-2:0], 1'b0};
        r_bit_cnt <= r_bit_cnt + 4'd1;
        if (w_hit) begin
          r_match_cnt <= r_match_cnt + 4'd1;
        end
      end
      if (r_state == ST_REPORT) begin
        r_grant    <= '0;
        r_rr_ptr   <= r_grant_id + 2'd1;
        r_id_hold  <= r_grant_id;
        r_cnt_hold <= r_match_cnt;
      end
    end
  end

  // The live counter is final during REPORT; outside it the last reported result is held
  assign done      = (r_state == ST_REPORT);
  assign done_id   = done ? r_grant_id  : r_id_hold;
  assign match_cnt = done ? r_match_cnt : r_cnt_hold;
  assign grant     = r_grant;
  assign busy      = (r_state != ST_IDLE);
  assign ser_out   = (r_state == ST_SHIFT) && r_shreg[FRAME_BITS-1];

endmodule

// File: tb/tb_fsm_lane_arbiter.sv
// tb/tb_fsm_lane_arbiter.sv - directed self-checking bench for fsm_lane_arbiter
module tb_fsm_lane_arbiter;

  logic        clock;
  logic        reset;
  logic [3:0]  req;
  logic [31:0] data;
  logic [3:0]  grant;
  logic        busy;
  logic        ser_out;
  logic        done;
  logic [1:0]  done_id;
  logic [3:0]  match_cnt;

  int n_checks = 0;
  int n_errors = 0;
  int cyc = 0;

  fsm_lane_arbiter #(.FRAME_BITS(8)) dut (
    .clock     (clock),
    .reset     (reset),
    .req       (req),
    .data      (data),
    .grant     (grant),
    .busy      (busy),
    .ser_out   (ser_out),
    .done      (done),
    .done_id   (done_id),
    .match_cnt (match_cnt)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  always @(posedge clock) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  task automatic set_word(input int idx, input logic [7:0] w);
    data[idx*8 +: 8] = w;
  endtask

  // Called at the negedge just before the grant edge; returns at the negedge one cycle after REPORT
  task automatic serve(input logic [1:0] id, input logic [7:0] word, input logic [3:0] cnt,
                       input bit drop_req, output int done_cyc);
    logic [3:0] oh;
    oh = 4'b0001 << id;
    done_cyc = -1;
    for (int j = 0; j <= 9; j++) begin
      @(negedge clock);
      if (j <= 8) begin
        check("grant", {28'd0, grant}, {28'd0, oh});
        check("busy", {31'd0, busy}, 32'd1);
      end else begin
        check("grant_off", {28'd0, grant}, 32'd0);
        check("busy_off", {31'd0, busy}, 32'd0);
      end
      if (j < 8) check("ser_out", {31'd0, ser_out}, {31'd0, word[7-j]});
      else       check("ser_idle", {31'd0, ser_out}, 32'd0);
      check("done", {31'd0, done}, (j == 8) ? 32'd1 : 32'd0);
      if (j >= 8) begin
        check("done_id", {30'd0, done_id}, {30'd0, id});
        check("match_cnt", {28'd0, match_cnt}, {28'd0, cnt});
      end
      if (j == 8) done_cyc = cyc;
      if (drop_req && j == 2) begin
        req  = 4'b0000;
        data = $urandom;
      end
    end
  endtask

  int dc;
  int prev_dc;

  initial begin
    reset = 1'b1;
    req   = 4'b0000;
    data  = 32'd0;
    repeat (2) @(negedge clock);
    check("rst_grant", {28'd0, grant}, 32'd0);
    check("rst_busy", {31'd0, busy}, 32'd0);
    check("rst_ser", {31'd0, ser_out}, 32'd0);
    check("rst_done", {31'd0, done}, 32'd0);
    check("rst_id", {30'd0, done_id}, 32'd0);
    check("rst_cnt", {28'd0, match_cnt}, 32'd0);

    // Single requester, req and data disturbed mid-frame
    reset = 1'b0;
    req   = 4'b0001;
    set_word(0, 8'b10110110);
    serve(2'd0, 8'b10110110, 4'd2, 1'b1, dc);
    @(negedge clock);
    check("idle_grant", {28'd0, grant}, 32'd0);
    check("idle_busy", {31'd0, busy}, 32'd0);

    // Assorted words on requester 1
    req = 4'b0010;
    set_word(1, 8'b10101011);
    serve(2'd1, 8'b10101011, 4'd1, 1'b0, dc);
    set_word(1, 8'b11111111);
    serve(2'd1, 8'b11111111, 4'd0, 1'b0, dc);
    set_word(1, 8'b00000000);
    serve(2'd1, 8'b00000000, 4'd0, 1'b0, dc);

    // Wrap-around: serve 2, then 0101 goes to 0 before 2
    req = 4'b0100;
    set_word(2, 8'b10111011);
    set_word(0, 8'b00000000);
    serve(2'd2, 8'b10111011, 4'd2, 1'b0, dc);
    req = 4'b0101;
    serve(2'd0, 8'b00000000, 4'd0, 1'b0, dc);
    serve(2'd2, 8'b10111011, 4'd2, 1'b0, dc);
    req = 4'b1000;
    set_word(3, 8'b10111011);
    serve(2'd3, 8'b10111011, 4'd2, 1'b0, dc);

    // All requesting: strict rotation starting at 0, 10-cycle done spacing
    req  = 4'b1111;
    data = {4{8'b10111011}};
    prev_dc = -1;
    for (int n = 0; n < 5; n++) begin
      serve(2'(n % 4), 8'b10111011, 4'd2, 1'b0, dc);
      if (n > 0) check("done_period", dc - prev_dc, 32'd10);
      prev_dc = dc;
    end

    // No match across a frame boundary
    req = 4'b0010;
    set_word(1, 8'b00000101);
    serve(2'd1, 8'b00000101, 4'd0, 1'b0, dc);
    set_word(1, 8'b10000000);
    serve(2'd1, 8'b10000000, 4'd0, 1'b0, dc);

    // Reset in the 4th SHIFT cycle of a frame on requester 3
    req = 4'b0100;
    serve(2'd2, 8'b10111011, 4'd2, 1'b0, dc);
    req = 4'b1000;
    @(negedge clock);
    check("pre_rst_grant", {28'd0, grant}, 32'b1000);
    repeat (3) begin
      @(negedge clock);
      check("pre_rst_done", {31'd0, done}, 32'd0);
    end
    reset = 1'b1;
    req   = 4'b1010;
    @(negedge clock);
    check("abort_grant", {28'd0, grant}, 32'd0);
    check("abort_busy", {31'd0, busy}, 32'd0);
    check("abort_ser", {31'd0, ser_out}, 32'd0);
    check("abort_done", {31'd0, done}, 32'd0);
    check("abort_id", {30'd0, done_id}, 32'd0);
    check("abort_cnt", {28'd0, match_cnt}, 32'd0);
    reset = 1'b0;
    set_word(1, 8'b10110110);
    serve(2'd1, 8'b10110110, 4'd2, 1'b0, dc);

    req = 4'b0000;
    @(negedge clock);
    check("end_grant", {28'd0, grant}, 32'd0);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/fsm_lane_arbiter.md
FSM_LANE_ARBITER -- requirements
Module: fsm_lane_arbiter

Interface
REQ-001 Parameter: FRAME_BITS, 8, bits per frame shifted serially through the shared detector lane (legal range 4..15).
REQ-002 Port: clock  input  1  sole clock; all state updates on rising edge.
REQ-003 Port: reset  input  1  synchronous, active-high reset.
REQ-004 Port: req  input  4  level request per requester 0..3.
REQ-005 Port: data  input  4*FRAME_BITS  frame word per requester; requester i uses bits [i*FRAME_BITS +: FRAME_BITS].
REQ-006 Port: grant  output  4  one-hot grant, high for the whole frame being served.
REQ-007 Port: busy  output  1  high while a frame is in SHIFT or REPORT.
REQ-008 Port: ser_out  output  1  bit currently presented to the detector lane; 0 outside SHIFT.
REQ-009 Port: done  output  1  one-cycle pulse, frame result valid.
REQ-010 Port: done_id  output  2  index of the served requester, valid when done=1.
REQ-011 Port: match_cnt  output  4  number of pattern matches in the frame, valid when done=1.

Function
REQ-012 Detected pattern is fixed at 1011 (first bit shifted first); overlapping matches shall be counted.
REQ-013 States: IDLE, SHIFT, REPORT.
REQ-014 IDLE, req==0: stay IDLE.
REQ-015 IDLE, req!=0 at edge k: grant the first requesting index at or after rr_ptr (wrapping 3->0), latch that requester's word, clear match counter and detector, go SHIFT.
REQ-016 SHIFT: each cycle present the next bit MSB first on ser_out; the edge ending that cycle consumes the bit; FRAME_BITS cycles (edges k+1..k+FRAME_BITS), then go REPORT.
REQ-017 The match counter shall increment at the same edge that consumes the bit completing a 1011 match, so the count is final on entry to REPORT.
REQ-018 REPORT (one cycle, after edge k+FRAME_BITS): done=1, done_id=granted index, match_cnt=final count; at the next edge go IDLE, grant=0, rr_ptr=granted index+1 mod 4.
REQ-019 The earliest next grant shall occur at edge k+FRAME_BITS+2, giving a 10-cycle frame period at FRAME_BITS=8.
REQ-020 req and data changes after the grant edge shall be ignored until the frame completes; dropping req mid-frame shall not abort the frame.
REQ-021 If several requesters are held high continuously, service order shall be strictly round-robin, with no requester served twice while another waits.
REQ-022 done_id and match_cnt shall hold their last values outside REPORT; done shall be 0 outside REPORT.
REQ-023 The detector state shall not carry between frames; a match spanning two frames shall not be counted.

Reset
REQ-024 reset=1 at an edge: state=IDLE, grant=0, busy=0, ser_out=0, done=0, done_id=0, match_cnt=0, rr_ptr=0, detector in its initial state.
REQ-025 Reset asserted mid-frame shall abort the frame with no done pulse; reset has priority over all other inputs.

Structure
REQ-026 A shared package shall hold the state enum, the pattern constant 4'b1011, and the requester count constant 4.
REQ-027 The 1011 detector shall be a sub-module seq_detect, with ports clock, reset, clr, valid, bit_in and a combinational hit that is high when the valid bit_in completes a match.
REQ-028 The arbiter, shift register, bit counter and match counter shall reside in fsm_lane_arbiter.

Verification
REQ-029 req=0001, word0=8'b10110110 -> grant=0001 for 9 cycles, done at cycle 9 after the grant edge, done_id=0, match_cnt=2.
REQ-030 req=0010, word1=8'b10101011 -> match_cnt=1; word1=8'b11111111 -> match_cnt=0; word1=8'b00000000 -> match_cnt=0.
REQ-031 req=1111 held, all words 8'b10111011 -> done_id sequence 0,1,2,3,0, each match_cnt=2, done pulses 10 cycles apart.
REQ-032 After serving requester 2, req=0101 -> next grant goes to requester 0 (wrap), then requester 2.
REQ-033 Reset pulsed in the 4th SHIFT cycle -> no done, grant=0 on the next cycle, next request starts round-robin from index 0.
REQ-034 Back-to-back frames 8'b00000101 then 8'b10000000 from the same requester -> both match_cnt=0 (no cross-frame match).
